// File: rtl/imul_pkg.sv
// rtl/imul_pkg.sv - shared op encodings, FSM state type and Alpha opcode decode for imul_iter
// Contents:
//   OP_MULL/OP_MULQ/OP_UMULH/OP_RSVD  2-bit op codes presented on imul_iter.op
//   state_t                           IDLE/RUN/DONE
//   alpha_to_op(opcode, func)         maps Alpha INTM (0x13) function codes to op
package imul_pkg;

  localparam logic [1:0] OP_MULL  = 2'd0;
  localparam logic [1:0] OP_MULQ  = 2'd1;
  localparam logic [1:0] OP_UMULH = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // /V variants (0x40, 0x60) share the plain op codes; trap detection lives upstream.
  function automatic logic [1:0] alpha_to_op(input logic [5:0] opcode, input logic [6:0] func);
    logic [1:0] o;
    o = OP_RSVD;
    if (opcode == 6'h13) begin
      case (func)
        7'h00, 7'h40: o = OP_MULL;
        7'h20, 7'h60: o = OP_MULQ;
        7'h30:        o = OP_UMULH;
        default:      o = OP_RSVD;
      endcase
    end
    return o;
  endfunction

endpackage

// File: rtl/imul_step.sv
// rtl/imul_step.sv - one radix-2^BPC partial-product-and-accumulate slice
// Ports:
//   acc_in   in  2*WIDTH  running accumulator
//   m        in  2*WIDTH  shifted multiplicand
//   q_chunk  in  BPC      low multiplier bits retired this cycle
//   acc_out  out 2*WIDTH  acc_in + m * q_chunk, truncated to 2*WIDTH (unsigned)
module imul_step #(
  parameter int WIDTH = 64,
  parameter int BPC   = 8
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [2*WIDTH-1:0] m,
  input  logic [BPC-1:0]     q_chunk,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [2*WIDTH-1:0] q_ext;

  always_comb begin
    q_ext   = {{(2*WIDTH-BPC){1'b0}}, q_chunk};
    acc_out = acc_in + (m * q_ext);
  end

endmodule

// File: rtl/imul_iter.sv
// rtl/imul_iter.sv - iterative MULL/MULQ/UMULH engine with early termination
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready        operation handshake; a, b, op, tag sampled at accept
//   flush                    kills any in-flight operation, blocks accept
//   out_valid/out_ready      result handshake; result and out_tag held until taken
//   busy                     high while in RUN or DONE
module imul_iter
  import imul_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int BPC   = 8,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic [TAG_W-1:0] tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int AW = 2 * WIDTH;
  localparam int HW = WIDTH / 2;
  localparam int NF = WIDTH / BPC;
  localparam int NH = HW / BPC;
  localparam int CW = $clog2(NF + 1);

  state_t             state_q, state_d;
  logic [AW-1:0]      m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;

  logic [AW-1:0]      acc_step;
  logic [WIDTH-1:0]   q_shift;

  imul_step #(.WIDTH(WIDTH), .BPC(BPC)) u_step (
    .acc_in (acc_q),
    .m      (m_q),
    .q_chunk(q_q[BPC-1:0]),
    .acc_out(acc_step)
  );

  function automatic logic [WIDTH-1:0] form_result(input logic [1:0] o, input logic [AW-1:0] acc);
    logic [WIDTH-1:0] r;
    case (o)
      OP_MULQ:  r = acc[WIDTH-1:0];
      OP_UMULH: r = acc[AW-1:WIDTH];
      OP_MULL:  r = {{HW{acc[HW-1]}}, acc[HW-1:0]};
      default:  r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    tag_d     = tag_q;
    result_d  = result_q;
    out_tag_d = out_tag_q;
    q_shift   = q_q >> BPC;

    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          op_d  = op;
          tag_d = tag;
          acc_d = '0;
          // MULL only needs the low longwords; loading them zero-extended halves N.
          if (op == OP_MULL) begin
            m_d   = {{(AW-HW){1'b0}}, a[HW-1:0]};
            q_d   = {{(WIDTH-HW){1'b0}}, b[HW-1:0]};
            cnt_d = CW'(NH);
          end else begin
            m_d   = {{WIDTH{1'b0}}, a};
            q_d   = b;
            cnt_d = CW'(NF);
          end
          if (op == OP_RSVD) begin
            state_d   = DONE;
            result_d  = '0;
            out_tag_d = tag;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        acc_d = acc_step;
        m_d   = m_q << BPC;
        q_d   = q_shift;
        cnt_d = cnt_q - CW'(1);
        // Remaining multiplier bits all zero means no further partial products.
        if (cnt_q == CW'(1) || q_shift == '0) begin
          state_d   = DONE;
          result_d  = form_result(op_q, acc_step);
          out_tag_d = tag_q;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over every handshake; keep the visible result registers untouched.
    if (flush) begin
      state_d   = IDLE;
      result_d  = result_q;
      out_tag_d = out_tag_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      op_q      <= OP_MULQ;
      tag_q     <= '0;
      result_q  <= '0;
      out_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      tag_q     <= tag_d;
      result_q  <= result_d;
      out_tag_q <= out_tag_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_imul_iter.sv
// tb/tb_imul_iter.sv - directed-vector bench for imul_iter
module tb_imul_iter;
  import imul_pkg::*;

  localparam int WIDTH = 64;
  localparam int BPC   = 8;
  localparam int TAG_W = 6;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [1:0]       op = OP_MULQ;
  logic [TAG_W-1:0] tag = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int total = 0;
  int bad   = 0;

  imul_iter #(.WIDTH(WIDTH), .BPC(BPC), .TAG_W(TAG_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .tag      (tag),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .out_tag  (out_tag),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%h expected=0x%h", name, got, exp);
    end
  endtask

  // Offer one op, hold until the accept edge, then scramble operands.
  task automatic start_op(input logic [1:0] o, input logic [63:0] av, input logic [63:0] bv,
                          input logic [TAG_W-1:0] t);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("start_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    op = o; a = av; b = bv; tag = t;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 64'hA5A5_A5A5_A5A5_A5A5;
    b = 64'h5A5A_5A5A_5A5A_5A5A;
    op = OP_MULQ;
    tag = '0;
  endtask

  // lat counts edges from (and including) the accept edge to out_valid high.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [63:0] av,
                        input logic [63:0] bv, input logic [TAG_W-1:0] t,
                        input logic [63:0] exp_res, input int exp_lat);
    int lat;
    out_ready = 1'b1;
    start_op(o, av, bv, t);
    wait_valid(lat);
    check({name, "_result"}, result, exp_res);
    check({name, "_tag"}, 64'(out_tag), 64'(t));
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    @(posedge clk); #1;
    check({name, "_ovalid_drop"}, 64'(out_valid), 64'd0);
    check({name, "_iready_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic seen;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    check("dec_mull", 64'(alpha_to_op(6'h13, 7'h00)), 64'(OP_MULL));
    check("dec_mulqv", 64'(alpha_to_op(6'h13, 7'h60)), 64'(OP_MULQ));
    check("dec_umulh", 64'(alpha_to_op(6'h13, 7'h30)), 64'(OP_UMULH));
    check("dec_other", 64'(alpha_to_op(6'h10, 7'h20)), 64'(OP_RSVD));

    run_op("mulq_3x5", OP_MULQ, 64'd3, 64'd5, 6'h05, 64'd15, 2);
    run_op("umulh_ones", OP_UMULH, ONES, ONES, 6'h21, 64'hFFFF_FFFF_FFFF_FFFE, 9);
    run_op("mulq_ones", OP_MULQ, ONES, ONES, 6'h22, 64'd1, 9);
    run_op("mull_sext", OP_MULL, 64'h0000_0000_7FFF_FFFF, 64'd2, 6'h31,
           64'hFFFF_FFFF_FFFF_FFFE, 2);
    run_op("mull_hi_ign", OP_MULL, 64'hDEAD_0000_0000_0004, 64'd3, 6'h32, 64'hC, 2);
    run_op("mull_neg", OP_MULL, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 6'h33,
           64'd1, 5);
    run_op("rsvd", OP_RSVD, 64'd9, 64'd9, 6'h2A, 64'd0, 1);

    // Back-pressure: 100*200 = 20000 held for 5 cycles.
    out_ready = 1'b0;
    start_op(OP_MULQ, 64'd100, 64'd200, 6'h11);
    wait_valid(lat);
    check("bp_lat", 64'(lat), 64'd2);
    for (int i = 0; i < 5; i++) begin
      check("bp_result", result, 64'd20000);
      check("bp_tag", 64'(out_tag), 64'h11);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ovalid", 64'(out_valid), 64'd0);
    check("bp_release_iready", 64'(in_ready), 64'd1);
    check("bp_release_busy", 64'(busy), 64'd0);

    // Flush before the third RUN iteration of a full-length op.
    start_op(OP_MULQ, ONES, ONES, 6'h03);
    check("run_busy", 64'(busy), 64'd1);
    check("run_in_ready", 64'(in_ready), 64'd0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("flush_no_valid", 64'(seen), 64'd0);
    run_op("mulq_7x6", OP_MULQ, 64'd7, 64'd6, 6'h07, 64'd42, 2);

    // Flush in IDLE blocks an offered op.
    in_valid = 1'b1; flush = 1'b1; op = OP_MULQ; a = 64'd2; b = 64'd2; tag = 6'h15;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("idle_flush_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("idle_flush_no_valid", 64'(seen), 64'd0);

    // Asynchronous reset between edges in the middle of RUN.
    start_op(OP_UMULH, ONES, ONES, 6'h09);
    @(posedge clk); #1;
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_result", result, 64'd0);
    check("arst_out_tag", 64'(out_tag), 64'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_stays_idle", 64'(busy), 64'd0);
    run_op("rsvd_after_rst", OP_RSVD, 64'd1, 64'd1, 6'h3C, 64'd0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
